// File: rtl/debug_pkg.sv
// Shared constants for the UART debug command engine: command/response codes,
// FSM state encodings and word-to-byte sizing.
package debug_pkg;

    localparam int unsigned NB_BYTE        = 8;
    localparam int unsigned NB_DATA_DEF    = 32;
    localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE;
    localparam int unsigned NB_BCNT        = 3;
    localparam int unsigned NB_IDX         = $clog2(BYTES_PER_WORD);
    localparam int unsigned NB_STATE       = 4;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_READ = 8'h52;
    localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;
    localparam logic [NB_BYTE-1:0] RSP_ACK  = 8'h06;
    localparam logic [NB_BYTE-1:0] RSP_NAK  = 8'h15;

    localparam logic [NB_STATE-1:0] ST_IDLE      = 4'd0;
    localparam logic [NB_STATE-1:0] ST_LOAD_CNT  = 4'd1;
    localparam logic [NB_STATE-1:0] ST_LOAD_DATA = 4'd2;
    localparam logic [NB_STATE-1:0] ST_WRITE     = 4'd3;
    localparam logic [NB_STATE-1:0] ST_STEP      = 4'd4;
    localparam logic [NB_STATE-1:0] ST_RSEL      = 4'd5;
    localparam logic [NB_STATE-1:0] ST_RWAIT     = 4'd6;
    localparam logic [NB_STATE-1:0] ST_RUN       = 4'd7;
    localparam logic [NB_STATE-1:0] ST_SEND      = 4'd8;
    localparam logic [NB_STATE-1:0] ST_WAIT_TX   = 4'd9;

endpackage

// File: rtl/debug_word_sender.sv
// Serializes 1..4 bytes of a word (LSB first) over the UART transmit handshake.
// o_done_c flags the cycle in which the final byte's i_tx_done arrives.
module debug_word_sender
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_word,
    input  logic [NB_BCNT-1:0] i_nbytes,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_done_c
);

    logic               r_active;
    logic [NB_BCNT-1:0] r_left;
    logic [NB_DATA-1:0] r_word;
    logic               r_tx_start;
    logic [NB_BYTE-1:0] r_tx_data;

    // Each byte is launched the cycle after the previous byte's tx_done
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_active   <= 1'b0;
            r_left     <= '0;
            r_word     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (i_start) begin
                r_active   <= 1'b1;
                r_left     <= i_nbytes - NB_BCNT'(1);
                r_tx_start <= 1'b1;
                r_tx_data  <= i_word[NB_BYTE-1:0];
                r_word     <= i_word >> NB_BYTE;
            end else if (r_active && i_tx_done) begin
                if (r_left == '0) begin
                    r_active <= 1'b0;
                end else begin
                    r_left     <= r_left - NB_BCNT'(1);
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_word[NB_BYTE-1:0];
                    r_word     <= r_word >> NB_BYTE;
                end
            end
        end
    end

    assign o_done_c   = r_active && i_tx_done && (r_left == '0);
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule

// File: rtl/uart_debug_unit.sv
// Host command engine behind the UART: parses load/step/read/run commands,
// drives instruction-memory writes and processor control, and returns responses.
module uart_debug_unit
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA    = NB_DATA_DEF,
    parameter int unsigned NB_ADDR    = 10,
    parameter int unsigned NB_REG_SEL = 5
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_imem_we,
    output logic [NB_ADDR-1:0]    o_imem_addr,
    output logic [NB_DATA-1:0]    o_imem_data,
    output logic [NB_REG_SEL-1:0] o_reg_sel,
    input  logic [NB_DATA-1:0]    i_reg_data,
    output logic                  o_step,
    output logic                  o_run,
    input  logic                  i_halt,
    output logic                  o_busy
);

    logic [NB_STATE-1:0]     r_state,      w_state_nxt;
    logic [NB_BYTE-1:0]      r_cnt,        w_cnt_nxt;
    logic [NB_IDX-1:0]       r_idx,        w_idx_nxt;
    logic [NB_DATA-9:0]      r_word,       w_word_nxt;
    logic [NB_ADDR-1:0]      r_addr,       w_addr_nxt;
    logic                    r_we,         w_we_nxt;
    logic [NB_DATA-1:0]      r_imem_data,  w_imem_data_nxt;
    logic [NB_REG_SEL-1:0]   r_reg_sel,    w_reg_sel_nxt;
    logic                    r_step,       w_step_nxt;
    logic                    r_run,        w_run_nxt;
    logic                    r_busy;
    logic [NB_DATA-1:0]      r_rsp_word,   w_rsp_word_nxt;
    logic [NB_BCNT-1:0]      r_rsp_nbytes, w_rsp_nbytes_nxt;
    logic [NB_DATA-1:0]      w_word_full;
    logic                    w_snd_start;
    logic                    w_snd_done_c;

    // New byte enters at the top, so the first byte received ends up in bits 7:0
    assign w_word_full = {i_rx_data, r_word};
    assign w_snd_start = (r_state == ST_SEND);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_word_nxt       = r_word;
        w_addr_nxt       = r_addr;
        w_we_nxt         = 1'b0;
        w_imem_data_nxt  = r_imem_data;
        w_reg_sel_nxt    = r_reg_sel;
        w_step_nxt       = 1'b0;
        w_run_nxt        = r_run;
        w_rsp_word_nxt   = r_rsp_word;
        w_rsp_nbytes_nxt = r_rsp_nbytes;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: w_state_nxt = ST_LOAD_CNT;
                        CMD_STEP: begin
                            w_state_nxt = ST_STEP;
                            w_step_nxt  = 1'b1;
                        end
                        CMD_READ: w_state_nxt = ST_RSEL;
                        CMD_RUN: begin
                            w_state_nxt = ST_RUN;
                            w_run_nxt   = 1'b1;
                        end
                        default: begin
                            w_rsp_word_nxt   = NB_DATA'(RSP_NAK);
                            w_rsp_nbytes_nxt = NB_BCNT'(1);
                            w_state_nxt      = ST_SEND;
                        end
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_done) begin
                    w_cnt_nxt  = i_rx_data;
                    w_addr_nxt = '0;
                    w_idx_nxt  = '0;
                    if (i_rx_data == '0) begin
                        w_rsp_word_nxt   = NB_DATA'(RSP_ACK);
                        w_rsp_nbytes_nxt = NB_BCNT'(1);
                        w_state_nxt      = ST_SEND;
                    end else begin
                        w_state_nxt = ST_LOAD_DATA;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (i_rx_done) begin
                    w_word_nxt = w_word_full[NB_DATA-1:NB_BYTE];
                    w_idx_nxt  = r_idx + NB_IDX'(1);
                    if (r_idx == NB_IDX'(BYTES_PER_WORD - 1)) begin
                        w_imem_data_nxt = w_word_full;
                        w_we_nxt        = 1'b1;
                        w_state_nxt     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                w_addr_nxt = r_addr + NB_ADDR'(1);
                w_cnt_nxt  = r_cnt - NB_BYTE'(1);
                if (r_cnt == NB_BYTE'(1)) begin
                    w_rsp_word_nxt   = NB_DATA'(RSP_ACK);
                    w_rsp_nbytes_nxt = NB_BCNT'(1);
                    w_state_nxt      = ST_SEND;
                end else begin
                    w_state_nxt = ST_LOAD_DATA;
                end
            end
            ST_STEP: begin
                w_rsp_word_nxt   = NB_DATA'(RSP_ACK);
                w_rsp_nbytes_nxt = NB_BCNT'(1);
                w_state_nxt      = ST_SEND;
            end
            ST_RSEL: begin
                if (i_rx_done) begin
                    w_reg_sel_nxt = i_rx_data[NB_REG_SEL-1:0];
                    w_idx_nxt     = '0;
                    w_state_nxt   = ST_RWAIT;
                end
            end
            // First cycle lets the new select settle; register data is captured on the second
            ST_RWAIT: begin
                if (r_idx == '0) begin
                    w_idx_nxt = NB_IDX'(1);
                end else begin
                    w_rsp_word_nxt   = i_reg_data;
                    w_rsp_nbytes_nxt = NB_BCNT'(BYTES_PER_WORD);
                    w_state_nxt      = ST_SEND;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_run_nxt        = 1'b0;
                    w_rsp_word_nxt   = NB_DATA'(RSP_ACK);
                    w_rsp_nbytes_nxt = NB_BCNT'(1);
                    w_state_nxt      = ST_SEND;
                end
            end
            ST_SEND:    w_state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (w_snd_done_c) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_imem_data  <= '0;
            r_reg_sel    <= '0;
            r_step       <= 1'b0;
            r_run        <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_word   <= '0;
            r_rsp_nbytes <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_word       <= w_word_nxt;
            r_addr       <= w_addr_nxt;
            r_we         <= w_we_nxt;
            r_imem_data  <= w_imem_data_nxt;
            r_reg_sel    <= w_reg_sel_nxt;
            r_step       <= w_step_nxt;
            r_run        <= w_run_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_rsp_word   <= w_rsp_word_nxt;
            r_rsp_nbytes <= w_rsp_nbytes_nxt;
        end
    end

    debug_word_sender #(
        .NB_DATA (NB_DATA)
    ) u_sender (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_start    (w_snd_start),
        .i_word     (r_rsp_word),
        .i_nbytes   (r_rsp_nbytes),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_done_c   (w_snd_done_c)
    );

    assign o_imem_we   = r_we;
    assign o_imem_addr = r_addr;
    assign o_imem_data = r_imem_data;
    assign o_reg_sel   = r_reg_sel;
    assign o_step      = r_step;
    assign o_run       = r_run;
    assign o_busy      = r_busy;

endmodule
